// File: rtl/counter_pkg.sv
// Shared types for the counter reload sequencer.
// load_req_t is the default-width request layout; counter_load_ctrl uses the same layout at its WIDTH.
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 5;

  typedef struct packed {
    logic                     imm;
    logic [DEFAULT_WIDTH-1:0] data;
  } load_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    LOAD
  } load_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty derive only from the occupancy register.
// clr empties the FIFO synchronously and overrides any push or pop in the same cycle.
module sync_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     clr,
  input  logic                     push,
  input  T                         wdata,
  input  logic                     pop,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign occupancy = cnt_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/counter_load_ctrl.sv
// Reload sequencer: queues preset requests and drives the counter's load/data, either immediately
// or seamlessly at terminal count. Define COUNTER_LOAD_CTRL_FLUSH_EN to add a synchronous flush input.
module counter_load_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned MATCH = 2**WIDTH - 1
) (
  input  logic                     clk,
  input  logic                     rst_,
`ifdef COUNTER_LOAD_CTRL_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WIDTH-1:0]         req_data,
  input  logic                     req_imm,
  input  logic [WIDTH-1:0]         count,
  output logic                     load,
  output logic [WIDTH-1:0]         data,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int unsigned OW = $clog2(DEPTH) + 1;
  // Entering LOAD one edge early puts the load pulse on the MATCH cycle; MATCH=0 wraps to all-ones.
  localparam logic [WIDTH-1:0] CMP = WIDTH'(MATCH - 1);

  typedef struct packed {
    logic             imm;
    logic [WIDTH-1:0] data;
  } req_t;

  load_state_e      state_q, state_d;
  req_t             head, wreq;
  logic             push, pop, full, empty, do_flush, load_d;
  logic [WIDTH-1:0] data_d;

`ifdef COUNTER_LOAD_CTRL_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  assign req_ready = !full;
  assign push      = req_valid && req_ready && !do_flush;
  assign pop       = (state_q == LOAD);
  assign wreq      = '{imm: req_imm, data: req_data};

  sync_fifo #(
    .T     (req_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_      (rst_),
    .clr       (do_flush),
    .push      (push),
    .wdata     (wreq),
    .pop       (pop),
    .rdata     (head),
    .full      (full),
    .empty     (empty),
    .occupancy (pending)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      load    <= 1'b0;
      data    <= '0;
    end else begin
      state_q <= state_d;
      load    <= load_d;
      data    <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (push) state_d = WAIT;
      WAIT: if (!empty && (head.imm || count == CMP)) state_d = LOAD;
      // Head pops at the end of LOAD; stay busy if anything else is queued or arriving.
      LOAD: state_d = ((pending > OW'(1)) || push) ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
    if (do_flush) state_d = IDLE;
  end

  always_comb begin
    load_d = (state_d == LOAD);
    data_d = load_d ? head.data : data;
  end

endmodule

// File: tb/tb_counter_load_ctrl.sv
// Bench for counter_load_ctrl: directed vector table, hand-written corner sequences and a
// randomized run against a timestamp/queue reference model.
module tb_counter_load_ctrl;

  localparam int unsigned W = 5;
  localparam int unsigned D = 4;
  localparam logic [W-1:0] CMPV = 5'd30;

  logic         clk = 1'b0;
  logic         rst_ = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_imm = 1'b0;
  logic [W-1:0] req_data = '0;
  logic [W-1:0] count = '0;
  logic         req_ready;
  logic         load;
  logic [W-1:0] data;
  logic [2:0]   pending;
`ifdef COUNTER_LOAD_CTRL_FLUSH_EN
  logic         flush = 1'b0;
`endif

  counter_load_ctrl #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
`ifdef COUNTER_LOAD_CTRL_FLUSH_EN
    .flush     (flush),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_imm   (req_imm),
    .count     (count),
    .load      (load),
    .data      (data),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic         v;
    logic         imm;
    logic [W-1:0] d;
    logic [W-1:0] cnt;
    logic         e_load;
    logic [W-1:0] e_data;
    logic [2:0]   e_pend;
    logic         e_rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic v, input logic imm, input logic [W-1:0] d,
                         input logic [W-1:0] cnt, input logic el, input logic [W-1:0] ed,
                         input logic [2:0] ep, input logic er);
    vec_t x;
    x.v = v; x.imm = imm; x.d = d; x.cnt = cnt;
    x.e_load = el; x.e_data = ed; x.e_pend = ep; x.e_rdy = er;
    tbl.push_back(x);
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ = 1'b1;
  endtask

  typedef struct {
    logic         imm;
    logic [W-1:0] d;
  } mreq_t;

  mreq_t        mq[$];
  logic         m_load, nl, acc, prev_l;
  logic [W-1:0] m_data, cnt, cnt_n, prev_d;
  logic [W-1:0] ld_d[3];
  logic [W-1:0] ld_c[3];
  int           ld_t[3];
  int           nload;
  bit           seen;

  initial begin
    // Reset, then idle.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst load", 32'(load), 0);
      check("rst pending", 32'(pending), 0);
      check("rst ready", 32'(req_ready), 1);
      check("rst data", 32'(data), 0);
    end
    rst_ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("idle load", 32'(load), 0);
      check("idle pending", 32'(pending), 0);
      check("idle ready", 32'(req_ready), 1);
    end

    // Immediate load, deferred load, full FIFO and drain at successive terminal counts.
    add_vec(1, 1, 5'h0A,  0, 0, 5'h00, 1, 1);
    add_vec(0, 0, 5'h00,  1, 1, 5'h0A, 1, 1);
    add_vec(0, 0, 5'h00,  2, 0, 5'h0A, 0, 1);
    add_vec(0, 0, 5'h00, 10, 0, 5'h0A, 0, 1);
    add_vec(1, 0, 5'h03, 28, 0, 5'h0A, 1, 1);
    add_vec(0, 0, 5'h00, 29, 0, 5'h0A, 1, 1);
    add_vec(0, 0, 5'h00, 30, 1, 5'h03, 1, 1);
    add_vec(0, 0, 5'h00, 31, 0, 5'h03, 0, 1);
    add_vec(0, 0, 5'h00,  3, 0, 5'h03, 0, 1);
    add_vec(1, 0, 5'h01,  5, 0, 5'h03, 1, 1);
    add_vec(1, 0, 5'h02,  5, 0, 5'h03, 2, 1);
    add_vec(1, 0, 5'h03,  5, 0, 5'h03, 3, 1);
    add_vec(1, 0, 5'h04,  5, 0, 5'h03, 4, 0);
    add_vec(1, 0, 5'h09,  5, 0, 5'h03, 4, 0);
    add_vec(0, 0, 5'h00, 30, 1, 5'h01, 4, 0);
    add_vec(0, 0, 5'h00, 31, 0, 5'h01, 3, 1);
    add_vec(0, 0, 5'h00, 30, 1, 5'h02, 3, 1);
    add_vec(0, 0, 5'h00, 31, 0, 5'h02, 2, 1);
    add_vec(0, 0, 5'h00, 30, 1, 5'h03, 2, 1);
    add_vec(0, 0, 5'h00, 31, 0, 5'h03, 1, 1);
    add_vec(0, 0, 5'h00, 30, 1, 5'h04, 1, 1);
    add_vec(0, 0, 5'h00, 31, 0, 5'h04, 0, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      req_valid = tbl[i].v; req_imm = tbl[i].imm; req_data = tbl[i].d; count = tbl[i].cnt;
      @(posedge clk); #1;
      check($sformatf("vec%0d load", i), 32'(load), 32'(tbl[i].e_load));
      check($sformatf("vec%0d data", i), 32'(data), 32'(tbl[i].e_data));
      check($sformatf("vec%0d pending", i), 32'(pending), 32'(tbl[i].e_pend));
      check($sformatf("vec%0d ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
    end
    req_valid = 1'b0;

    // Mixed order: imm 7, deferred 12, imm 1 against a free-running counter.
    do_reset();
    cnt = 5'd20; count = cnt; prev_l = 0; prev_d = '0; nload = 0;
    for (int i = 0; i < 3; i++) begin ld_d[i] = '0; ld_c[i] = '0; ld_t[i] = 0; end
    for (int i = 0; i < 200 && nload < 3; i++) begin
      req_valid = (i < 3);
      req_imm   = (i != 1);
      req_data  = (i == 0) ? 5'd7 : (i == 1) ? 5'd12 : 5'd1;
      @(posedge clk); #1;
      cnt = prev_l ? prev_d : cnt + 5'd1;
      count = cnt;
      if (load) begin
        ld_d[nload] = data; ld_c[nload] = cnt; ld_t[nload] = i; nload++;
      end
      prev_l = load; prev_d = data;
    end
    req_valid = 1'b0;
    check("mixed load count", 32'(nload), 3);
    check("mixed first", 32'(ld_d[0]), 7);
    check("mixed second", 32'(ld_d[1]), 12);
    check("mixed third", 32'(ld_d[2]), 1);
    check("mixed deferred at 31", 32'(ld_c[1]), 31);
    check("mixed gap", 32'(ld_t[2] - ld_t[1]), 2);

    // Reset asserted while a load pulse is high, with a second request still queued.
    do_reset();
    count = 5'd5;
    req_valid = 1'b1; req_imm = 1'b1; req_data = 5'h11;
    @(posedge clk); #1;
    req_data = 5'h12;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = load;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      seen = load;
    end
    check("midrst load seen", 32'(seen), 1);
    rst_ = 1'b0;
    #1;
    check("midrst load async", 32'(load), 0);
    check("midrst pending", 32'(pending), 0);
    check("midrst data", 32'(data), 0);
    check("midrst ready", 32'(req_ready), 1);
    @(negedge clk);
    rst_ = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      count = 5'(i);
      @(posedge clk); #1;
      if (load) seen = 1;
    end
    check("midrst no later load", 32'(seen), 0);
    check("midrst pending after", 32'(pending), 0);

    // Randomized run against the reference model, including external counter jumps.
    do_reset();
    mq.delete(); m_load = 0; m_data = '0; cnt = '0;
    for (int k = 0; k < 3000; k++) begin
      req_valid = ($urandom_range(0, 2) == 0);
      req_imm   = ($urandom_range(0, 3) != 0);
      req_data  = 5'($urandom);
      if ($urandom_range(0, 49) == 0) cnt = 5'($urandom);
      count = cnt;
      acc = req_valid && (mq.size() < D);
      // A head may load only if the previous cycle was not itself a load pulse.
      nl = !m_load && (mq.size() > 0) && (mq[0].imm || cnt == CMPV);
      cnt_n = m_load ? m_data : cnt + 5'd1;
      if (m_load) void'(mq.pop_front());
      if (nl) m_data = mq[0].d;
      if (acc) mq.push_back('{imm: req_imm, d: req_data});
      m_load = nl;
      @(posedge clk); #1;
      check("rand load", 32'(load), 32'(m_load));
      check("rand data", 32'(data), 32'(m_data));
      check("rand pending", 32'(pending), 32'(mq.size()));
      check("rand ready", 32'(req_ready), 32'(mq.size() < D));
      cnt = cnt_n;
    end
    req_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
